// File: rtl/mux_tree_pipe.sv
// Pipelined 2**SEL_W:1 mux tree, one register stage per level, valid/ready flow control.
// Optional MUX_TREE_PERF_CNT_EN adds a saturating 16-bit output handshake counter (xfer_cnt).
module mux_tree_pipe #(
    parameter int unsigned DATA_W = 1,
    parameter int unsigned SEL_W  = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [(2**SEL_W)*DATA_W-1:0]    inp,
    input  logic [SEL_W-1:0]                sel,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [DATA_W-1:0]               out_data,
    output logic [SEL_W-1:0]                out_sel,
    output logic                            out_valid,
    input  logic                            out_ready
`ifdef MUX_TREE_PERF_CNT_EN
    ,
    output logic [15:0]                     xfer_cnt
`endif
);

    localparam int unsigned N = 2 ** SEL_W;

    logic [SEL_W-1:0] valid_vec;
    logic [SEL_W-1:0] load;

    assign in_ready = load[0] && !rst;

    for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
        localparam int unsigned NODES = N >> (k + 1);

        logic [2*NODES*DATA_W-1:0] src;
        logic                      src_valid;
        logic [SEL_W-1:0]          src_sel;
        logic [NODES*DATA_W-1:0]   mux;
        logic [NODES*DATA_W-1:0]   data_q;
        logic                      valid_q;
        logic [SEL_W-1:0]          sel_q;

        if (k == 0) begin : g_head
            assign src       = inp;
            assign src_valid = in_valid;
            assign src_sel   = sel;
        end else begin : g_body
            assign src       = g_lvl[k-1].data_q;
            assign src_valid = g_lvl[k-1].valid_q;
            assign src_sel   = g_lvl[k-1].sel_q;
        end

        // A stage can load whenever any stage from here to the output has room,
        // which lets bubbles collapse while the output is stalled.
        assign load[k]      = out_ready || !(&valid_vec[SEL_W-1:k]);
        assign valid_vec[k] = valid_q;

        always_comb begin
            mux = '0;
            for (int j = 0; j < int'(NODES); j++) begin
                mux[j*DATA_W +: DATA_W] = src_sel[k] ? src[(2*j+1)*DATA_W +: DATA_W]
                                                     : src[(2*j)*DATA_W +: DATA_W];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                sel_q   <= '0;
            end else if (load[k]) begin
                valid_q <= src_valid;
                data_q  <= mux;
                sel_q   <= src_sel;
            end
        end
    end

    assign out_valid = g_lvl[SEL_W-1].valid_q;
    assign out_data  = g_lvl[SEL_W-1].data_q;
    assign out_sel   = g_lvl[SEL_W-1].sel_q;

`ifdef MUX_TREE_PERF_CNT_EN
    logic [15:0] xfer_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt_q <= '0;
        end else if (out_valid && out_ready && xfer_cnt_q != 16'hFFFF) begin
            xfer_cnt_q <= xfer_cnt_q + 16'd1;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench for mux_tree_pipe (DATA_W=8, SEL_W=5) with a scoreboard of
// expected results pushed on input handshakes and popped on output handshakes.
module tb_mux_tree_pipe;

    localparam int DW = 8;
    localparam int SW = 5;
    localparam int NI = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NI*DW-1:0]  inp;
    logic [SW-1:0]     sel;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     out_data;
    logic [SW-1:0]     out_sel;
    logic              out_valid;
    logic              out_ready;
`ifdef MUX_TREE_PERF_CNT_EN
    logic [15:0]       xfer_cnt;
`endif

    mux_tree_pipe #(
        .DATA_W (DW),
        .SEL_W  (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inp       (inp),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUX_TREE_PERF_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] sel;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   push_cnt = 0;
    int   hs_cnt   = 0;

    // Scoreboard monitor: pop/compare on output handshakes, then push accepted requests.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                hs_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got data=%h sel=%0d, required no output",
                             out_data, out_sel);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data || out_sel !== e.sel) begin
                        errors++;
                        $display("FAIL sb_result: got data=%h sel=%0d, required data=%h sel=%0d",
                                 out_data, out_sel, e.data, e.sel);
                    end
                end
            end
            if (in_valid && in_ready) begin
                e.data = inp[int'(sel)*DW +: DW];
                e.sel  = sel;
                sb.push_back(e);
                push_cnt++;
            end
        end
    end

    task automatic drive(input logic iv, input logic [SW-1:0] s, input logic ordy);
        @(posedge clk);
        #1;
        in_valid  = iv;
        sel       = s;
        out_ready = ordy;
    endtask

    task automatic rand_inp();
        for (int i = 0; i < NI; i++) inp[i*DW +: DW] = 8'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        sel = '0;
        inp = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        checks++;
        if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h, required 00", out_data); end
        checks++;
        if (out_sel !== 5'd0) begin errors++; $display("FAIL rst_out_sel: got %0d, required 0", out_sel); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_single();
        int first = -1;
        logic [DW-1:0] od = '0;
        logic [SW-1:0] os = '0;
        logic ov6 = 1'b1;
        drive(1'b1, 5'd17, 1'b1);
        for (int i = 0; i < NI; i++) inp[i*DW +: DW] = 8'(i + 8'h40);
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            #1;
            if (out_valid === 1'b1 && first < 0) begin
                first = n;
                od = out_data;
                os = out_sel;
            end
            if (n == 6) ov6 = out_valid;
            drive(1'b0, '0, 1'b1);
        end
        checks++;
        if (first != 5) begin errors++; $display("FAIL single_latency: got %0d, required 5", first); end
        checks++;
        if (od !== 8'h51) begin errors++; $display("FAIL single_data: got %h, required 51", od); end
        checks++;
        if (os !== 5'd17) begin errors++; $display("FAIL single_sel: got %0d, required 17", os); end
        checks++;
        if (ov6 !== 1'b0) begin errors++; $display("FAIL single_once: got out_valid=%b, required 0", ov6); end
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL single_drain: got %0d left, required 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        int hs0 = hs_cnt;
        for (int n = 0; n < 46; n++) begin
            if (n < 32) begin
                drive(1'b1, 5'(n), 1'b1);
                rand_inp();
            end else begin
                drive(1'b0, '0, 1'b1);
            end
            @(negedge clk);
            #1;
            if (n < 32) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_in_ready n=%0d: got %b, required 1", n, in_ready);
                end
            end
            checks++;
            if (out_valid !== ((n >= 5 && n <= 36) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL stream_out_valid n=%0d: got %b, required %b", n, out_valid,
                         (n >= 5 && n <= 36));
            end
        end
        drain();
        checks++;
        if (hs_cnt - hs0 != 32) begin errors++; $display("FAIL stream_count: got %0d, required 32", hs_cnt - hs0); end
    endtask

    task automatic test_stall();
        int hs0 = hs_cnt;
        logic [DW-1:0] od = '0;
        logic [SW-1:0] os = '0;
        for (int n = 0; n < 10; n++) begin
            drive(1'b1, 5'(n), 1'b0);
            rand_inp();
            @(negedge clk);
            #1;
            checks++;
            if (in_ready !== ((n < 5) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL stall_in_ready n=%0d: got %b, required %b", n, in_ready, (n < 5));
            end
            if (n == 5) begin
                od = out_data;
                os = out_sel;
                checks++;
                if (out_valid !== 1'b1 || out_sel !== 5'd0) begin
                    errors++;
                    $display("FAIL stall_head: got valid=%b sel=%0d, required valid=1 sel=0",
                             out_valid, out_sel);
                end
            end
            if (n > 5) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== od || out_sel !== os) begin
                    errors++;
                    $display("FAIL stall_hold n=%0d: got %b/%h/%0d, required 1/%h/%0d",
                             n, out_valid, out_data, out_sel, od, os);
                end
            end
        end
        for (int n = 0; n < 10; n++) begin
            drive(1'b1, 5'(n + 10), 1'b1);
            rand_inp();
        end
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL stall_drain: got %0d left, required 0", sb.size()); end
        checks++;
        if (hs_cnt - hs0 != 15) begin errors++; $display("FAIL stall_count: got %0d, required 15", hs_cnt - hs0); end
    endtask

    task automatic test_random();
        int p0 = push_cnt;
        int hs0 = hs_cnt;
        int cyc = 0;
        logic iv = 1'b1;
        while (push_cnt - p0 < 1000 && cyc < 20000) begin
            drive(iv, 5'($urandom), 1'($urandom));
            rand_inp();
            iv = ~iv;
            cyc++;
        end
        checks++;
        if (cyc >= 20000) begin errors++; $display("FAIL random_timeout: got %0d accepted, required 1000", push_cnt - p0); end
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL random_drain: got %0d left, required 0", sb.size()); end
        checks++;
        if (hs_cnt - hs0 != push_cnt - p0) begin
            errors++;
            $display("FAIL random_count: got %0d outputs, required %0d", hs_cnt - hs0, push_cnt - p0);
        end
    endtask

    task automatic test_reset_flight();
        int hs0 = hs_cnt;
        int stray = 0;
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 5'(n + 3), 1'b1);
            rand_inp();
        end
        drive(1'b0, '0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flight_rst_in_ready: got %b, required 0", in_ready); end
        drive(1'b0, '0, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flight_out_valid: got %b, required 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flight_in_ready: got %b, required 1", in_ready); end
        for (int n = 0; n < 8; n++) begin
            drive(1'b0, '0, 1'b1);
            @(negedge clk);
            #1;
            if (out_valid !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0 || hs_cnt != hs0) begin
            errors++;
            $display("FAIL flight_stale: got %0d valid cycles %0d outputs, required 0 0", stray, hs_cnt - hs0);
        end
    endtask

`ifdef MUX_TREE_PERF_CNT_EN
    task automatic test_perf_cnt();
        for (int i = 0; i < 70000; i++) drive(1'b1, 5'($urandom), 1'b1);
        drain();
        checks++;
        if (xfer_cnt !== 16'hFFFF) begin errors++; $display("FAIL perf_sat: got %h, required ffff", xfer_cnt); end
        drive(1'b0, '0, 1'b1);
        rst = 1'b1;
        drive(1'b0, '0, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (xfer_cnt !== 16'h0000) begin errors++; $display("FAIL perf_rst: got %h, required 0000", xfer_cnt); end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_flight();
`ifdef MUX_TREE_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
